// File: rtl/rom_lector_secuencial_if.sv
// Bus between the sequential ROM reader and its environment:
// ROM address/data, start request, delivery handshake and scan results.
interface rom_lector_secuencial_if #(
  parameter int ANCHO_DIR  = 8,
  parameter int ANCHO_DATO = 8,
  parameter int ANCHO_SUMA = 16
);
  logic                  inicio;
  logic [ANCHO_DIR-1:0]  dir_ini;
  logic [ANCHO_DIR-1:0]  dir_fin;
  logic [ANCHO_DIR-1:0]  Dir;
  logic [ANCHO_DATO-1:0] Dato_s;
  logic [ANCHO_DATO-1:0] dato_o;
  logic                  valido;
  logic                  listo_in;
  logic [ANCHO_SUMA-1:0] suma;
  logic [ANCHO_DATO-1:0] maximo;
  logic                  ocupado;
  logic                  fin;

  modport master (
    input  inicio, dir_ini, dir_fin, Dato_s, listo_in,
    output Dir, dato_o, valido, suma, maximo, ocupado, fin
  );

  modport slave (
    output inicio, dir_ini, dir_fin, Dato_s, listo_in,
    input  Dir, dato_o, valido, suma, maximo, ocupado, fin
  );
endinterface

// File: rtl/rom_lector_secuencial.sv
// Walks ROM addresses dir_ini..dir_fin, hands each word downstream
// over valid/ready and keeps running sum and maximum of the scan.
module rom_lector_secuencial #(
  parameter int ANCHO_DIR  = 8,
  parameter int ANCHO_DATO = 8,
  parameter int ANCHO_SUMA = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  rom_lector_secuencial_if.master bus
);
  localparam logic [1:0] REPOSO  = 2'd0;
  localparam logic [1:0] LEE     = 2'd1;
  localparam logic [1:0] ENTREGA = 2'd2;
  localparam logic [1:0] FIN     = 2'd3;
  localparam logic [ANCHO_DIR-1:0] UNO = ANCHO_DIR'(1);

  logic [1:0]            estado_q, estado_d;
  logic [ANCHO_DIR-1:0]  dir_q, dir_d;
  logic [ANCHO_DIR-1:0]  fin_reg_q, fin_reg_d;
  logic [ANCHO_DATO-1:0] dato_q, dato_d;
  logic                  valido_q, valido_d;
  logic [ANCHO_SUMA-1:0] suma_q, suma_d;
  logic [ANCHO_DATO-1:0] max_q, max_d;
  logic                  ocupado_q, ocupado_d;
  logic                  fin_q, fin_d;

  always_comb begin
    estado_d  = estado_q;
    dir_d     = dir_q;
    fin_reg_d = fin_reg_q;
    dato_d    = dato_q;
    valido_d  = valido_q;
    suma_d    = suma_q;
    max_d     = max_q;
    fin_d     = (estado_q == FIN);
    unique case (estado_q)
      REPOSO: begin
        if (bus.inicio) begin
          fin_reg_d = bus.dir_fin;
          dir_d     = bus.dir_ini;
          suma_d    = '0;
          max_d     = '0;
          estado_d  = (bus.dir_ini <= bus.dir_fin) ? LEE : FIN;
        end
      end
      LEE: begin
        dato_d   = bus.Dato_s;
        valido_d = 1'b1;
        suma_d   = suma_q + ANCHO_SUMA'(bus.Dato_s);
        max_d    = (bus.Dato_s > max_q) ? bus.Dato_s : max_q;
        estado_d = ENTREGA;
      end
      ENTREGA: begin
        if (valido_q && bus.listo_in) begin
          valido_d = 1'b0;
          // equality stop: a scan ending at the top address never wraps
          if (dir_q == fin_reg_q) begin
            estado_d = FIN;
          end else begin
            dir_d    = dir_q + UNO;
            estado_d = LEE;
          end
        end
      end
      FIN: begin
        estado_d = REPOSO;
      end
    endcase
    ocupado_d = (estado_d != REPOSO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= REPOSO;
      dir_q     <= '0;
      fin_reg_q <= '0;
      dato_q    <= '0;
      valido_q  <= 1'b0;
      suma_q    <= '0;
      max_q     <= '0;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      dir_q     <= dir_d;
      fin_reg_q <= fin_reg_d;
      dato_q    <= dato_d;
      valido_q  <= valido_d;
      suma_q    <= suma_d;
      max_q     <= max_d;
      ocupado_q <= ocupado_d;
      fin_q     <= fin_d;
    end
  end

  assign bus.Dir     = dir_q;
  assign bus.dato_o  = dato_q;
  assign bus.valido  = valido_q;
  assign bus.suma    = suma_q;
  assign bus.maximo  = max_q;
  assign bus.ocupado = ocupado_q;
  assign bus.fin     = fin_q;
endmodule

// File: tb/tb_rom_lector_secuencial.sv
// Directed bench for rom_lector_secuencial with a 12-word ROM model.
// Table of scans plus backpressure, mid-scan start and reset sequences.
module tb_rom_lector_secuencial;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rom_lector_secuencial_if #(.ANCHO_DIR(8), .ANCHO_DATO(8), .ANCHO_SUMA(16)) bus ();

  rom_lector_secuencial #(.ANCHO_DIR(8), .ANCHO_DATO(8), .ANCHO_SUMA(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] rom [12];
  initial begin
    rom = '{8'd90, 8'd80, 8'd40, 8'd60, 8'd50, 8'd40,
            8'd30, 8'd20, 8'd10, 8'd100, 8'd101, 8'd102};
  end
  assign bus.Dato_s = (bus.Dir < 8'd12) ? rom[bus.Dir[3:0]] : 8'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      ini;
    logic [7:0]      fin;
    int              n;
    logic [0:3][7:0] w;
    int              suma;
    int              maxv;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_scan(input vec_t v, input bit poke);
    int got;
    int first_v;
    int fin_idx;
    int fins;
    bus.dir_ini = v.ini;
    bus.dir_fin = v.fin;
    bus.inicio  = 1'b1;
    @(posedge clk);
    #1 bus.inicio = 1'b0;
    got = 0; first_v = 0; fin_idx = 0; fins = 0;
    for (int cyc = 1; cyc <= 1000 && fins == 0; cyc++) begin
      @(negedge clk);
      if (poke && cyc == 1) begin
        bus.inicio  = 1'b1;
        bus.dir_ini = 8'd0;
        bus.dir_fin = 8'd3;
      end
      if (poke && cyc == 2) bus.inicio = 1'b0;
      if (bus.valido && bus.listo_in) begin
        if (first_v == 0) first_v = cyc;
        if (got < 4 && got < v.n) chk("word", int'(bus.dato_o), int'(v.w[got]));
        got++;
      end
      if (bus.fin) begin
        fins++;
        fin_idx = cyc;
      end
    end
    chk("fin_seen", fins, 1);
    chk("n_words", got, v.n);
    if (v.n > 0) chk("lat_valido", first_v, 2);
    else         chk("lat_fin", fin_idx, 2);
    chk("suma", int'(bus.suma), v.suma);
    chk("maximo", int'(bus.maximo), v.maxv);
    chk("ocupado_end", int'(bus.ocupado), 0);
    @(negedge clk);
    chk("fin_single", int'(bus.fin), 0);
    chk("suma_hold", int'(bus.suma), v.suma);
  endtask

  initial begin
    vec_t bp;
    int   seen;
    int   got;
    int   fins;
    checks = 0;
    errors = 0;
    vecs[0] = '{ini: 8'd0, fin: 8'd3, n: 4, w: {8'd90, 8'd80, 8'd40, 8'd60}, suma: 270, maxv: 90};
    vecs[1] = '{ini: 8'd8, fin: 8'd11, n: 4, w: {8'd10, 8'd100, 8'd101, 8'd102}, suma: 313, maxv: 102};
    vecs[2] = '{ini: 8'd4, fin: 8'd7, n: 4, w: {8'd50, 8'd40, 8'd30, 8'd20}, suma: 140, maxv: 50};
    vecs[3] = '{ini: 8'd5, fin: 8'd2, n: 0, w: '0, suma: 0, maxv: 0};
    vecs[4] = '{ini: 8'd2, fin: 8'd2, n: 1, w: {8'd40, 8'd0, 8'd0, 8'd0}, suma: 40, maxv: 40};
    vecs[5] = '{ini: 8'd0, fin: 8'd255, n: 256, w: {8'd90, 8'd80, 8'd40, 8'd60}, suma: 723, maxv: 102};
    vecs[6] = '{ini: 8'd255, fin: 8'd255, n: 1, w: '0, suma: 0, maxv: 0};

    bus.inicio   = 1'b0;
    bus.dir_ini  = 8'd0;
    bus.dir_fin  = 8'd0;
    bus.listo_in = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("rst_Dir", int'(bus.Dir), 0);
    chk("rst_valido", int'(bus.valido), 0);
    chk("rst_ocupado", int'(bus.ocupado), 0);
    chk("rst_fin", int'(bus.fin), 0);
    chk("rst_suma", int'(bus.suma), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_scan(vecs[i], 1'b0);

    // start request while busy must not restart or extend the scan
    bp = '{ini: 8'd9, fin: 8'd9, n: 1, w: {8'd100, 8'd0, 8'd0, 8'd0}, suma: 100, maxv: 100};
    run_scan(bp, 1'b1);
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", int'(bus.ocupado), 0);

    // backpressure on the first word of scan 0..1
    bus.listo_in = 1'b0;
    bus.dir_ini  = 8'd0;
    bus.dir_fin  = 8'd1;
    bus.inicio   = 1'b1;
    @(posedge clk);
    #1 bus.inicio = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (bus.valido) seen = 1;
    end
    chk("bp_valido_seen", seen, 1);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("bp_dato", int'(bus.dato_o), 90);
      chk("bp_valido", int'(bus.valido), 1);
      chk("bp_Dir", int'(bus.Dir), 0);
    end
    bus.listo_in = 1'b1;
    got = 0; fins = 0;
    for (int c = 0; c < 20 && fins == 0; c++) begin
      @(negedge clk);
      if (bus.valido) begin
        chk("bp_word2", int'(bus.dato_o), 80);
        got++;
      end
      if (bus.fin) fins++;
    end
    chk("bp_fin", fins, 1);
    chk("bp_n", got, 1);
    chk("bp_suma", int'(bus.suma), 170);
    @(negedge clk);

    // asynchronous reset during delivery of scan 0..11
    bus.dir_ini = 8'd0;
    bus.dir_fin = 8'd11;
    bus.inicio  = 1'b1;
    @(posedge clk);
    #1 bus.inicio = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (bus.valido) seen = 1;
    end
    chk("rs_valido_seen", seen, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rs_entrega", int'(bus.valido), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_Dir", int'(bus.Dir), 0);
    chk("rs_dato", int'(bus.dato_o), 0);
    chk("rs_valido", int'(bus.valido), 0);
    chk("rs_suma", int'(bus.suma), 0);
    chk("rs_maximo", int'(bus.maximo), 0);
    chk("rs_ocupado", int'(bus.ocupado), 0);
    chk("rs_fin", int'(bus.fin), 0);
    fins = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.fin) fins++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.fin) fins++;
    end
    chk("rs_no_fin", fins, 0);
    run_scan(vecs[4], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
